// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op encodings, FSM states and counter-width helper for mul_div
package mul_div_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: start/done handshake bundle (start, op, OperX, OperY -> Result, busy, done, div_by_zero)
interface mul_div_if #(parameter int DEVIDENT_LENGTH = 5, parameter int DIVISOR_LENGTH = 5);
  logic start;
  logic op;
  logic [DEVIDENT_LENGTH-1:0] OperX;
  logic [DIVISOR_LENGTH-1:0] OperY;
  logic [2*DEVIDENT_LENGTH-1:0] Result;
  logic busy;
  logic done;
  logic div_by_zero;
  modport master(output start, op, OperX, OperY, input Result, busy, done, div_by_zero);
  modport slave(input start, op, OperX, OperY, output Result, busy, done, div_by_zero);
endinterface

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: IDLE/CALC/DONE sequencer with N-step down counter (clk, rst, start -> load, step, finish, cnt, busy, done)
module mul_div_ctrl import mul_div_pkg::*; #(
  parameter int N = 5,
  localparam int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          load,
  output logic          step,
  output logic          finish,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done
);
  state_t state;
  assign load = state == IDLE && start;
  assign step = state == CALC;
  assign finish = step && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= load ? CALC : finish ? DONE : step ? CALC : IDLE;
      cnt <= load ? CW'(N - 1) : step ? cnt - CW'(1) : cnt;
      busy <= load | step;
      done <= finish;
    end
  end
endmodule

// File: rtl/mul_div.sv
// mul_div: iterative unsigned shift-add multiplier / restoring divider, one bit per clock (clk, rst, bus: mul_div_if.slave)
module mul_div import mul_div_pkg::*; #(
  parameter int DEVIDENT_LENGTH = 5,
  parameter int DIVISOR_LENGTH = 5
) (
  input logic clk,
  input logic rst,
  mul_div_if.slave bus
);
  localparam int N = DEVIDENT_LENGTH;
  localparam int M = DIVISOR_LENGTH;
  localparam int CW = cnt_w(N);
  logic load, step, finish, opr, ge, dbz;
  logic [CW-1:0] cnt, mi;
  logic [N-1:0] x, q, q_n;
  logic [M-1:0] y, rem, rem_n;
  logic [M:0] rem_s;
  logic [2*N-1:0] acc, acc_n;
  mul_div_ctrl #(.N(N)) u_ctrl (
    .clk(clk), .rst(rst), .start(bus.start), .load(load), .step(step),
    .finish(finish), .cnt(cnt), .busy(bus.busy), .done(bus.done)
  );
  assign mi = CW'(N - 1) - cnt;
  assign acc_n = acc + (x[mi] ? (2*N)'(y) << mi : '0);
  assign rem_s = {rem, x[cnt]};
  assign ge = rem_s >= (M+1)'(y);
  assign rem_n = M'(ge ? rem_s - (M+1)'(y) : rem_s);
  assign q_n = N'({q, ge});
  assign dbz = opr == OP_DIV && y == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      opr <= OP_MUL;
      acc <= '0;
      rem <= '0;
      q <= '0;
      bus.Result <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        x <= bus.OperX;
        y <= bus.OperY;
        opr <= bus.op;
        acc <= '0;
        rem <= '0;
        q <= '0;
      end else if (step) begin
        acc <= acc_n;
        rem <= rem_n;
        q <= q_n;
      end
      if (finish) bus.Result <= dbz ? {x, {N{1'b1}}} : opr == OP_DIV ? {N'(rem_n), q_n} : acc_n;
      bus.div_by_zero <= finish & dbz;
    end
  end
endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: self-checking bench with a cycle-level reference model and directed vectors for mul_div
module tb_mul_div;
  localparam int N = 5;
  localparam int M = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  mul_div_if #(.DEVIDENT_LENGTH(N), .DIVISOR_LENGTH(M)) bus();
  mul_div #(.DEVIDENT_LENGTH(N), .DIVISOR_LENGTH(M)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic logic [2*N-1:0] ref_res(input logic o, input logic [N-1:0] x, input logic [M-1:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (!o) return (2*N)'(xi * yi);
    if (yi == 0) return (2*N)'((xi << N) | ((1 << N) - 1));
    return (2*N)'(((xi % yi) << N) | (xi / yi));
  endfunction
  int t = -1;
  bit armed = 1'b0;
  logic [2*N-1:0] m_res = '0;
  logic [2*N-1:0] m_pend = '0;
  logic m_pdbz = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      t = -1;
      m_res = '0;
      armed = 1'b1;
    end else if (t < 0) begin
      if (bus.start) begin
        t = 0;
        m_pend = ref_res(bus.op, bus.OperX, bus.OperY);
        m_pdbz = bus.op && bus.OperY == '0;
      end
    end else begin
      t++;
      if (t == N) m_res = m_pend;
      if (t > N) t = -1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(bus.busy), 32'(t >= 0));
      check("done", 32'(bus.done), 32'(t == N));
      check("result", 32'(bus.Result), 32'(m_res));
      check("dbz", 32'(bus.div_by_zero), 32'(t == N && m_pdbz));
    end
  end
  task automatic run(input logic o, input logic [N-1:0] x, input logic [M-1:0] y,
                     output logic [2*N-1:0] res, output logic dz, output int lat);
    bus.start = 1'b1;
    bus.op = o;
    bus.OperX = x;
    bus.OperY = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = ~o;
    bus.OperX = N'($urandom);
    bus.OperY = M'($urandom);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      total++;
      $display("FAIL timeout: done never rose within %0d cycles", lat);
    end
    res = bus.Result;
    dz = bus.div_by_zero;
    @(negedge clk);
  endtask
  logic vo [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int vx [9] = '{1, 2, 31, 2, 31, 29, 13, 3, 7};
  int vy [9] = '{1, 5, 31, 5, 1, 4, 0, 3, 0};
  int ve [9] = '{1, 10, 961, 64, 31, 39, 447, 9, 0};
  logic vz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  initial begin
    logic [2*N-1:0] res;
    logic dz;
    int lat, pulses;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.OperX = '0;
    bus.OperY = '0;
    repeat (2) @(negedge clk);
    check("reset result", 32'(bus.Result), 0);
    check("reset busy", 32'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      run(vo[i], N'(vx[i]), M'(vy[i]), res, dz, lat);
      check($sformatf("vec%0d result", i), 32'(res), 32'(ve[i]));
      check($sformatf("vec%0d dbz", i), 32'(dz), 32'(vz[i]));
      check($sformatf("vec%0d latency", i), 32'(lat), 5);
    end
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.OperX = 5'd2;
    bus.OperY = 5'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.OperX = 5'd31;
    bus.OperY = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    res = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        pulses++;
        res = bus.Result;
      end
      @(negedge clk);
    end
    check("ignored start pulses", 32'(pulses), 1);
    check("ignored start result", 32'(res), 10);
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.OperX = 5'd31;
    bus.OperY = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    check("abort result", 32'(bus.Result), 0);
    rst = 1'b0;
    run(1'b1, 5'd29, 5'd4, res, dz, lat);
    check("after abort result", 32'(res), 39);
    check("after abort latency", 32'(lat), 5);
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [N-1:0] x;
        logic [M-1:0] y;
        x = i < 4 ? ((i & 1) != 0 ? '1 : '0) : N'($urandom);
        y = i < 4 ? ((i & 2) != 0 ? '1 : '0) : M'($urandom);
        run(o[0], x, y, res, dz, lat);
        check("random result", 32'(res), 32'(ref_res(o[0], x, y)));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
